// File: rtl/elbeth_dmem_controller.sv
// elbeth_dmem_controller: core data-port to single-port byte-enabled SRAM bridge with checks and wait states
// Ports: clk, rst (async active-low); core side dmem_addr/en/rw/out_data in, dmem_in_data/ready/error out;
// SRAM side ram_addr/en/we/wdata out, ram_rdata in (valid 1+WAIT_STATES cycles after ram_en).
module elbeth_dmem_controller #(
  parameter int MEM_ADDR_WIDTH = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               dmem_addr,
  input  logic                      dmem_en,
  input  logic [3:0]                dmem_rw,
  input  logic [31:0]               dmem_out_data,
  output logic [31:0]               dmem_in_data,
  output logic                      dmem_ready,
  output logic                      dmem_error,
  output logic [MEM_ADDR_WIDTH-3:0] ram_addr,
  output logic                      ram_en,
  output logic [3:0]                ram_we,
  output logic [31:0]               ram_wdata,
  input  logic [31:0]               ram_rdata
);
  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, READ, RESP} state_t;
  state_t state, state_d;
  logic [1:0] off, off_d, size, size_d, sz;
  logic wr, wr_d, bad, ready_d, error_d, en_d;
  logic [3:0] cnt, cnt_d, we_d;
  logic [31:0] in_data_d, wdata_d;
  logic [MEM_ADDR_WIDTH-3:0] addr_d;
  assign sz = dmem_rw[1:0];
  assign bad = dmem_rw[3] | (sz == 2'b11) | (sz == 2'b01 & dmem_addr[0]) |
               (sz == 2'b10 & |dmem_addr[1:0]) | |(dmem_addr >> MEM_ADDR_WIDTH);
  always_comb begin
    state_d = state;
    off_d = off;
    size_d = size;
    wr_d = wr;
    cnt_d = cnt;
    in_data_d = dmem_in_data;
    wdata_d = ram_wdata;
    addr_d = ram_addr;
    we_d = 4'b0000;
    en_d = 1'b0;
    ready_d = 1'b0;
    error_d = 1'b0;
    case (state)
      IDLE: if (dmem_en) begin
        if (bad) begin
          state_d = RESP;
          ready_d = 1'b1;
          error_d = 1'b1;
        end else begin
          state_d = ACCESS;
          en_d = 1'b1;
          addr_d = dmem_addr[MEM_ADDR_WIDTH-1:2];
          off_d = dmem_addr[1:0];
          size_d = sz;
          wr_d = dmem_rw[2];
          we_d = !dmem_rw[2] ? 4'b0000 :
                 sz == 2'b00 ? 4'b0001 << dmem_addr[1:0] :
                 sz == 2'b01 ? (dmem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
          wdata_d = sz == 2'b00 ? {4{dmem_out_data[7:0]}} :
                    sz == 2'b01 ? {2{dmem_out_data[15:0]}} : dmem_out_data;
        end
      end
      ACCESS: begin
        cnt_d = 4'(WAIT_STATES - 1);
        state_d = WAIT_STATES > 0 ? WAIT : wr ? RESP : READ;
        ready_d = WAIT_STATES == 0 && wr;
      end
      WAIT: begin
        cnt_d = cnt - 4'd1;
        state_d = cnt != 4'd0 ? WAIT : wr ? RESP : READ;
        ready_d = cnt == 4'd0 && wr;
      end
      READ: begin
        in_data_d = size == 2'b00 ? {24'b0, 8'(ram_rdata >> {off, 3'b000})} :
                    size == 2'b01 ? {16'b0, off[1] ? ram_rdata[31:16] : ram_rdata[15:0]} : ram_rdata;
        state_d = RESP;
        ready_d = 1'b1;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      off <= '0;
      size <= '0;
      wr <= 1'b0;
      cnt <= '0;
      dmem_in_data <= '0;
      dmem_ready <= 1'b0;
      dmem_error <= 1'b0;
      ram_addr <= '0;
      ram_en <= 1'b0;
      ram_we <= '0;
      ram_wdata <= '0;
    end else begin
      state <= state_d;
      off <= off_d;
      size <= size_d;
      wr <= wr_d;
      cnt <= cnt_d;
      dmem_in_data <= in_data_d;
      dmem_ready <= ready_d;
      dmem_error <= error_d;
      ram_addr <= addr_d;
      ram_en <= en_d;
      ram_we <= we_d;
      ram_wdata <= wdata_d;
    end
  end
endmodule
